// File: rtl/mxint_block_encoder.sv
// mxint_block_encoder: packs a serial stream of signed fixed-point values
// into MXINT blocks of BLOCK_SIZE mantissas that share one biased exponent.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting elements into blk[cnt], OR-ing magnitudes into orr
// EMIT  | block complete, presented on valid/ready until taken
module mxint_block_encoder #(
  parameter int DATA_IN_0_PRECISION_0  = 16,
  parameter int DATA_IN_0_PRECISION_1  = 8,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 8,
  parameter int BLOCK_SIZE             = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE-1:0],
  output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int W    = DATA_IN_0_PRECISION_0;
  localparam int F    = DATA_IN_0_PRECISION_1;
  localparam int M    = DATA_OUT_0_PRECISION_0;
  localparam int E    = DATA_OUT_0_PRECISION_1;
  localparam int N    = BLOCK_SIZE;
  localparam int CW   = $clog2(N);
  localparam int SW   = $clog2(W) + 1;
  localparam int BIAS = (2 ** (E - 1)) - 1;
  localparam int EMAX = (2 ** E) - 1;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   orr_q, orr_d;
  logic [W-1:0]   blk_q [N];
  logic [W-1:0]   blk_d [N];
  logic [W-1:0]   mag;

  // Ready is a pure function of state and reset; valid is just the EMIT state.
  assign data_in_0_ready  = (state_q == FILL) && rst;
  assign data_out_0_valid = (state_q == EMIT);

  // One's-complement magnitude: never sets the sign bit, so -1 counts as zero.
  assign mag = data_in_0[W-1] ? ~data_in_0 : data_in_0;

  // Next-state logic: collect elements in FILL, hold the block in EMIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    orr_d   = orr_q;
    blk_d   = blk_q;
    case (state_q)
      FILL: begin
        if (data_in_0_valid) begin
          blk_d[cnt_q] = data_in_0;
          orr_d        = orr_q | mag;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      EMIT: begin
        if (data_out_0_ready) begin
          state_d = FILL;
          orr_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counter, magnitude accumulator and element buffer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      orr_q   <= '0;
      for (int i = 0; i < N; i++) blk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      orr_q   <= orr_d;
      for (int i = 0; i < N; i++) blk_q[i] <= blk_d[i];
    end
  end

  // Shared shift from the top set bit of orr, then mantissas and clamped exponent.
  always_comb begin : encode
    int                  p;
    int                  s_int;
    int                  e_int;
    logic [SW-1:0]       shamt;
    logic signed [W-1:0] sh;
    p = -1;
    for (int i = 0; i < W; i++) begin
      if (orr_q[i]) p = i;
    end
    s_int = p + 2 - M;
    if (s_int < 0) s_int = 0;
    shamt = SW'(s_int);
    e_int = s_int - F + (M - 2) + BIAS;
    sh    = '0;
    for (int i = 0; i < N; i++) begin
      sh             = $signed(blk_q[i]) >>> shamt;
      mdata_out_0[i] = (orr_q == '0) ? '0 : sh[M-1:0];
    end
    if (orr_q == '0) begin
      edata_out_0 = '0;
    end else if (e_int < 0) begin
      edata_out_0 = '0;
    end else if (e_int > EMAX) begin
      edata_out_0 = '1;
    end else begin
      edata_out_0 = e_int[E-1:0];
    end
  end

endmodule

// File: tb/tb_mxint_block_encoder.sv
// Scoreboard bench for mxint_block_encoder with default parameters.
module tb_mxint_block_encoder;

  typedef logic signed [15:0] blk_t [4];
  typedef struct packed {
    logic [3:0][7:0] m;
    logic [7:0]      e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] data_in_0;
  logic        data_in_0_valid;
  logic        data_in_0_ready;
  logic [7:0]  mdata [3:0];
  logic [7:0]  edata;
  logic        out_valid;
  logic        out_ready;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_push   = 0;
  int   n_recv   = 0;

  mxint_block_encoder dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .mdata_out_0      (mdata),
    .edata_out_0      (edata),
    .data_out_0_valid (out_valid),
    .data_out_0_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic [7:0] m0, m1, m2, m3, input logic [7:0] e);
    exp_t r;
    r.m[0] = m0; r.m[1] = m1; r.m[2] = m2; r.m[3] = m3;
    r.e = e;
    return r;
  endfunction

  // Reference: smallest shift s for which every element fits in 8 signed bits.
  function automatic exp_t model(input blk_t v);
    exp_t r;
    int   s;
    int   t;
    int   e;
    bit   fits;
    bit   zero_mag;
    zero_mag = 1'b1;
    for (int i = 0; i < 4; i++)
      if (v[i] != 16'sd0 && v[i] != -16'sd1) zero_mag = 1'b0;
    for (s = 0; s < 16; s++) begin
      fits = 1'b1;
      for (int i = 0; i < 4; i++) begin
        t = int'(v[i]) >>> s;
        if (t < -128 || t > 127) fits = 1'b0;
      end
      if (fits) break;
    end
    for (int i = 0; i < 4; i++) begin
      t = int'(v[i]) >>> s;
      r.m[i] = zero_mag ? 8'h00 : t[7:0];
    end
    e = s - 8 + 6 + 127;
    if (e < 0) e = 0;
    if (e > 255) e = 255;
    r.e = zero_mag ? 8'h00 : e[7:0];
    return r;
  endfunction

  task automatic push(input exp_t x);
    q.push_back(x);
    n_push++;
  endtask

  // Drive one element, hold valid until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] x, input int gap);
    int   n;
    logic acc;
    n = 0;
    data_in_0_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    data_in_0       = x;
    data_in_0_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = data_in_0_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", {31'd0, acc}, 32'd1);
        break;
      end
    end
    data_in_0_valid = 1'b0;
  endtask

  task automatic send_block(input blk_t v, input int gap);
    for (int i = 0; i < 4; i++) send(v[i], gap);
  endtask

  // Output monitor: compare each handshaken block with the scoreboard head.
  always @(negedge clk) begin
    exp_t x;
    if (rst && out_valid && out_ready) begin
      n_recv++;
      if (q.size() == 0) begin
        check("sb_underflow", q.size(), 32'd1);
      end else begin
        x = q.pop_front();
        check("mant0", {24'd0, mdata[0]}, {24'd0, x.m[0]});
        check("mant1", {24'd0, mdata[1]}, {24'd0, x.m[1]});
        check("mant2", {24'd0, mdata[2]}, {24'd0, x.m[2]});
        check("mant3", {24'd0, mdata[3]}, {24'd0, x.m[3]});
        check("edata", {24'd0, edata}, {24'd0, x.e});
      end
    end
  end

  initial begin
    blk_t v;
    exp_t mixed;
    mixed = mk(8'd64, 8'd32, 8'hC0, 8'd16, 8'd127);

    rst = 1'b0; data_in_0 = '0; data_in_0_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, data_in_0_ready}, 32'd0);
    check("rst_edata", {24'd0, edata}, 32'd0);
    check("rst_mant0", {24'd0, mdata[0]}, 32'd0);
    check("rst_mant3", {24'd0, mdata[3]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, data_in_0_ready}, 32'd1);
    @(posedge clk); #1;

    // Mixed block with latency check.
    push(mixed);
    send(16'h0100, 0);
    send(16'h0080, 0);
    send(16'hFF00, 0);
    @(negedge clk);
    check("valid_before_last", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send(16'h0040, 0);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("emit_ready", {31'd0, data_in_0_ready}, 32'd0);
    @(posedge clk); #1;

    // Small values block held under backpressure while the next block waits.
    out_ready = 1'b0;
    push(mk(8'd3, 8'hFE, 8'd1, 8'd0, 8'd125));
    v = '{16'sd3, -16'sd2, 16'sd1, 16'sd0};
    send_block(v, 0);
    fork
      begin
        push(mk(8'h80, 8'd0, 8'd0, 8'd127, 8'd133));
        v = '{-16'sd32768, 16'sd0, 16'sd0, 16'sh7FFF};
        send_block(v, 0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", {31'd0, out_valid}, 32'd1);
          check("bp_ready", {31'd0, data_in_0_ready}, 32'd0);
          check("bp_mant1", {24'd0, mdata[1]}, 32'h0000_00FE);
          check("bp_edata", {24'd0, edata}, 32'd125);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join

    // All-zero block with idle gaps between elements.
    push(mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_block(v, 2);

    // Reset mid-fill discards the partial block.
    send(16'h1234, 1);
    send(16'h8001, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, data_in_0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid_after", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    push(mixed);
    v = '{16'sh0100, 16'sh0080, -16'sh0100, 16'sh0040};
    send_block(v, 0);

    // Random blocks of varied magnitude against the reference model.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = 16'($urandom);
        v[i] = v[i] >>> $urandom_range(0, 15);
      end
      push(model(v));
      send_block(v, $urandom_range(0, 2));
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", q.size(), 32'd0);
    check("blocks", n_recv, n_push);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mxint_block_encoder.md
# mxint_block_encoder

Converts a serial stream of signed fixed-point values into MXINT blocks: BLOCK_SIZE mantissas sharing one biased exponent. It is the producer side of the MXINT block interface that the mxint dot-product and linear layers consume, and sits between fixed-point activations and the first MXINT operator. One value is accepted per cycle. After a block is collected, the encoder picks the smallest shared shift that fits every element in the mantissa width. It then holds the block on a valid/ready output until the block is taken.

## Interface
- DATA_IN_0_PRECISION_0, 16: total width of each signed fixed-point input.
- DATA_IN_0_PRECISION_1, 8: fractional bits of the input (F).
- DATA_OUT_0_PRECISION_0, 8: signed mantissa width (M).
- DATA_OUT_0_PRECISION_1, 8: exponent width (E); bias = 2^(E-1)-1.
- BLOCK_SIZE, 4: elements per block (≥2).
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-low (0 = reset).
- data_in_0  in  DATA_IN_0_PRECISION_0  signed fixed-point element.
- data_in_0_valid  in  1  input valid.
- data_in_0_ready  out  1  input ready.
- mdata_out_0[BLOCK_SIZE-1:0]  out  M each  signed mantissas; index i is the i-th accepted element.
- edata_out_0  out  E  biased shared exponent.
- data_out_0_valid  out  1  block valid.
- data_out_0_ready  in  1  block ready.

## Operation
- States:
  - FILL: data_in_0_ready=1; each accepted element is written to buf[cnt], and cnt is incremented.
  - EMIT: data_in_0_ready=0; data_out_0_valid=1.
- FILL→EMIT on acceptance of element BLOCK_SIZE-1; cnt wraps to 0.
- EMIT→FILL on the output handshake (valid & ready).
- Magnitude accumulator: orr |= (x[W-1] ? ~x : x) on each accept; orr clears when a new block starts.
- p = index of the highest set bit of orr. Shift s = max(0, p+2-M), so every element fits in M signed bits.
- Mantissa: mdata_out_0[i] = buf[i] >>> s (arithmetic shift, truncation toward −inf), low M bits. No saturation is needed.
- Exponent: edata_out_0 = s − F + (M−2) + bias, clamped to [0, 2^E−1]. Mantissa binary point sits M−2 bits from the LSB, matching the dot-product convention.
- All-zero block (orr==0): all mantissas 0 and edata_out_0 = 0. This rule overrides the formula.
- Outputs are derived only from registered state, so they stay stable for the whole of EMIT.

## Timing
- Reset (rst=0 at a clock edge) gives:
  - state=FILL, cnt=0, orr=0, all buf=0;
  - data_out_0_valid=0, mdata_out_0 all 0, edata_out_0=0;
  - data_in_0_ready=0 while rst is low.
- Reset mid-block discards the partial block and any pending output block.
- Latency: last element accepted at edge t → data_out_0_valid=1 in the cycle after t.
- Throughput: BLOCK_SIZE+1 cycles per block with no backpressure. The output handshake cycle is not an input cycle; data_in_0_ready returns to 1 the next cycle.
- Backpressure: while data_out_0_ready=0 in EMIT, valid and all data hold; no input is accepted.
- data_in_0_valid=0 in FILL: cnt and orr hold, so gaps are allowed anywhere within a block.
- Combinational path: data_in_0_ready depends only on state/reset. There is no valid→ready path.

## Test plan
Defaults throughout (W=16, F=8, M=8, E=8, BLOCK_SIZE=4, bias 127).
- Mixed block: inputs 0x0100, 0x0080, 0xFF00, 0x0040 (1.0, 0.5, −1.0, 0.25).
  - Required: mantissas 64, 32, −64, 16; edata 127.
  - data_out_0_valid rises the cycle after the 4th accept.
- Small values: inputs 3, −2, 1, 0 (raw).
  - Required: s=0; mantissas 3, −2, 1, 0; edata 125.
- All-zero block → mantissas 0, 0, 0, 0; edata 0.
- Most negative: inputs 0x8000, 0, 0, 0x7FFF.
  - Required: s=8; mantissas −128, 0, 0, 127; edata 133.
- Backpressure: hold data_out_0_ready low 5 cycles in EMIT, with data_in_0_valid held high.
  - Required: outputs constant; data_in_0_ready=0; no element is lost.
  - After release, the next 4 elements form the next block correctly.
- Reset mid-fill: accept 2 elements, drive rst=0 for 1 cycle, then feed 0x0100, 0x0080, 0xFF00, 0x0040.
  - Required: valid=0 during reset.
  - Output block identical to the mixed-block scenario.
